// File: rtl/prio_encoder_q.sv
// Registered priority encoder: sticky request capture feeding a one-slot
// valid/ready output, with fixed-priority or round-robin winner selection.
module prio_encoder_q #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         rr_mode,
    output logic [W-1:0] out,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending,
    output logic         busy
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] out_q, out_d;
    logic         valid_q, valid_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [W-1:0] win;
    logic         free;
    logic         load;
    logic [N-1:0] load_mask;

    function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] p);
        logic [W-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) k = W'(i);
        end
        return k;
    endfunction

    // Descending scan starting at start, wrapping from 0 back to N-1.
    function automatic logic [W-1:0] pick_rr(input logic [N-1:0] p,
                                             input logic [W-1:0] start);
        logic [W-1:0] k;
        logic         found;
        int           j;
        k     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) - i;
            if (j < 0) j = j + N;
            if (!found && p[j]) begin
                found = 1'b1;
                k     = W'(j);
            end
        end
        return k;
    endfunction

    always_comb begin
        win = rr_mode ? pick_rr(pending_q, ptr_q) : pick_fixed(pending_q);
    end

    assign free      = !valid_q || ready;
    assign load      = free && (|pending_q);
    assign load_mask = load ? (N'(1) << win) : '0;

    always_comb begin
        pending_d = (pending_q & ~load_mask) | in;
        out_d     = out_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        if (load) begin
            out_d   = win;
            valid_d = 1'b1;
            ptr_d   = (win == '0) ? W'(N - 1) : win - 1'b1;
        end else if (free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= W'(N - 1);
        end else begin
            pending_q <= pending_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign busy    = (|pending_q) | valid_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: vector table, directed corner sequences and a
// randomized run against a behavioural model, on N=8 and N=5 builds.
module tb_prio_encoder_q;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in8 = '0;
    logic       rr8 = 1'b0;
    logic       rdy8 = 1'b0;
    logic [2:0] out8;
    logic       valid8;
    logic [7:0] pend8;
    logic       busy8;

    logic [4:0] in5 = '0;
    logic       rr5 = 1'b0;
    logic       rdy5 = 1'b0;
    logic [2:0] out5;
    logic       valid5;
    logic [4:0] pend5;
    logic       busy5;

    int checks = 0;
    int errors = 0;

    prio_encoder_q #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in(in8), .rr_mode(rr8), .out(out8),
        .valid(valid8), .ready(rdy8), .pending(pend8), .busy(busy8)
    );

    prio_encoder_q #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .in(in5), .rr_mode(rr5), .out(out5),
        .valid(valid5), .ready(rdy5), .pending(pend5), .busy(busy5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] in_v;
        logic       rr;
        logic       rdy;
        logic       exp_v;
        logic [2:0] exp_o;
        logic [7:0] exp_p;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in8 = '0;
        in5 = '0;
        #2;
        rst = 1'b0;
        #1;
    endtask

    // Reference: request set as a bit vector, winner found by a modular scan.
    task automatic model_step(input int n, input logic [7:0] inb, input bit rr, input bit rdy,
                              inout logic [7:0] pend, inout int ptr, inout int o, inout bit v);
        bit free;
        int k;
        free = !v || rdy;
        k = -1;
        if (free && pend != 0) begin
            for (int s = 0; s < n; s++) begin
                int j;
                j = rr ? (ptr - s + n) % n : (n - 1 - s);
                if (k < 0 && pend[j]) k = j;
            end
        end
        if (k >= 0) begin
            pend[k] = 1'b0;
            o = k;
            v = 1'b1;
            ptr = (k == 0) ? n - 1 : k - 1;
        end else if (free) begin
            v = 1'b0;
        end
        pend = pend | inb;
    endtask

    initial begin
        logic [7:0] m8_p, m5_p;
        int m8_ptr, m5_ptr, m8_o, m5_o;
        bit m8_v, m5_v;

        tbl[0]  = '{8'h94, 1'b0, 1'b1, 1'b0, 3'd0, 8'h94};
        tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd7, 8'h14};
        tbl[2]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h04};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00};
        tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
        tbl[5]  = '{8'h94, 1'b0, 1'b0, 1'b0, 3'd0, 8'h94};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h14};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h14};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h14};
        tbl[9]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h14};
        tbl[10] = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 8'h14};
        tbl[11] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h04};
        tbl[12] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00};
        tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};

        #1;
        check("reset_valid", valid8, 0);
        check("reset_out", out8, 0);
        check("reset_pending", pend8, 0);
        check("reset_busy", busy8, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed burst and backpressure
        for (int i = 0; i < 14; i++) begin
            in8  = tbl[i].in_v;
            rr8  = tbl[i].rr;
            rdy8 = tbl[i].rdy;
            tick();
            check($sformatf("tbl%0d_valid", i), valid8, tbl[i].exp_v);
            check($sformatf("tbl%0d_pending", i), pend8, tbl[i].exp_p);
            check($sformatf("tbl%0d_busy", i), busy8, (|tbl[i].exp_p) | tbl[i].exp_v);
            if (tbl[i].exp_v) check($sformatf("tbl%0d_out", i), out8, tbl[i].exp_o);
        end

        // Round-robin fairness, then fixed priority on the same load
        do_reset();
        in8 = 8'hFF; rr8 = 1'b1; rdy8 = 1'b1;
        tick();
        check("rr_first_valid", valid8, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("rr_valid%0d", i), valid8, 1);
            check($sformatf("rr_out%0d", i), out8, (7 - (i % 8)));
        end
        rr8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("fixed_ff_out%0d", i), out8, 7);
        end

        // Re-request in the cycle its pending bit loads
        do_reset();
        in8 = 8'h08; rr8 = 1'b0; rdy8 = 1'b1;
        tick();
        check("rereq_pend1", pend8, 8'h08);
        tick();
        check("rereq_out1", out8, 3);
        check("rereq_valid1", valid8, 1);
        check("rereq_pend2", pend8, 8'h08);
        in8 = 8'h00;
        tick();
        check("rereq_out2", out8, 3);
        check("rereq_valid2", valid8, 1);
        check("rereq_pend3", pend8, 8'h00);
        tick();
        check("rereq_idle", valid8, 0);

        // Asynchronous reset while a grant is held
        do_reset();
        in8 = 8'h20; rr8 = 1'b0; rdy8 = 1'b0;
        tick();
        in8 = 8'h0A;
        tick();
        in8 = 8'h00;
        tick();
        check("hold_out", out8, 5);
        check("hold_valid", valid8, 1);
        check("hold_pend", pend8, 8'h0A);
        #3 rst = 1'b1;
        #1;
        check("arst_out", out8, 0);
        check("arst_valid", valid8, 0);
        check("arst_pend", pend8, 0);
        check("arst_busy", busy8, 0);
        #1 rst = 1'b0;
        in8 = 8'h01; rr8 = 1'b1; rdy8 = 1'b1;
        tick();
        check("post_rst_pend", pend8, 8'h01);
        check("post_rst_valid0", valid8, 0);
        in8 = 8'h00;
        tick();
        check("post_rst_valid", valid8, 1);
        check("post_rst_out", out8, 0);
        check("post_rst_pend2", pend8, 0);

        // N=5 build
        do_reset();
        in5 = 5'b10001; rr5 = 1'b0; rdy5 = 1'b1;
        tick();
        in5 = '0;
        tick();
        check("n5_out_a", out5, 4);
        check("n5_valid_a", valid5, 1);
        tick();
        check("n5_out_b", out5, 0);
        tick();
        check("n5_idle", valid5, 0);

        // Randomized run against the model on both builds
        do_reset();
        m8_p = '0; m5_p = '0; m8_ptr = 7; m5_ptr = 4;
        m8_o = 0; m5_o = 0; m8_v = 0; m5_v = 0;
        for (int c = 0; c < 400; c++) begin
            in8  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            in5  = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h00;
            if ($urandom_range(0, 9) == 0) rr8 = ~rr8;
            if ($urandom_range(0, 9) == 0) rr5 = ~rr5;
            rdy8 = ($urandom_range(0, 9) < 7);
            rdy5 = ($urandom_range(0, 9) < 6);
            model_step(8, in8, rr8, rdy8, m8_p, m8_ptr, m8_o, m8_v);
            model_step(5, {3'b000, in5}, rr5, rdy5, m5_p, m5_ptr, m5_o, m5_v);
            tick();
            check("rnd8_valid", valid8, m8_v);
            check("rnd8_pend", pend8, m8_p);
            check("rnd8_busy", busy8, (m8_p != 0) || m8_v);
            if (m8_v) check("rnd8_out", out8, m8_o);
            check("rnd5_valid", valid5, m5_v);
            check("rnd5_pend", pend5, m5_p[4:0]);
            if (m5_v) check("rnd5_out", out5, m5_o);
            check("rnd5_range", (out5 < 3'd5), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
